// File: rtl/mccoy_seq_pkg.sv
// Shared types and defaults for the McCoy program sequencer.
//   seq_state_t  : sequencer FSM states
//   instr_t      : 6-bit McCoy instruction word
//   SEQ_DEPTH_DEFAULT / SEQ_NOP_DEFAULT : default parameter values
package mccoy_seq_pkg;

  localparam int unsigned SEQ_DEPTH_DEFAULT = 16;

  typedef logic [5:0] instr_t;

  localparam instr_t SEQ_NOP_DEFAULT = 6'b000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPURST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x 6-bit register array, one synchronous write port,
// one asynchronous read port. Contents are not reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : word to store
//   i_raddr : read index
//   o_rdata : word at i_raddr (combinational)
module seq_prog_mem
  import mccoy_seq_pkg::*;
#(
  parameter int unsigned DEPTH = SEQ_DEPTH_DEFAULT,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  instr_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output instr_t        o_rdata
);

  instr_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mccoy_sequencer.sv
// Loads a short program of McCoy instruction words, then on start resets the
// core for one cycle, streams the program into it one word per cycle, drains
// for one cycle and captures the core output as the result.
//   clk, reset            : clock, synchronous active-high reset
//   load_valid/load_instr : append one program word (accepted when load_ready)
//   load_ready            : idle, not full, no start/clear_prog this cycle
//   clear_prog            : empty the program store (idle only)
//   start                 : replay the stored program (idle, non-empty)
//   instr_out, cpu_rst    : registered drive to core io_in[7:2], io_in[1]
//   cpu_out               : core io_out[5:0]
//   busy, done, result    : run status, one-cycle done pulse, captured output
//   prog_len              : number of stored words
module mccoy_sequencer
  import mccoy_seq_pkg::*;
#(
  parameter int unsigned DEPTH     = SEQ_DEPTH_DEFAULT,
  parameter instr_t      NOP_INSTR = SEQ_NOP_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [5:0] load_instr,
  output logic       load_ready,
  input  logic       clear_prog,
  input  logic       start,
  output logic [5:0] instr_out,
  output logic       cpu_rst,
  input  logic [5:0] cpu_out,
  output logic       busy,
  output logic       done,
  output logic [5:0] result,
  output logic [4:0] prog_len
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_state_t    r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt, w_pc_inc, w_rd_addr;
  logic [4:0]    r_len;
  instr_t        r_instr, r_result, w_rd_data, w_instr_nxt;
  logic          r_cpu_rst, r_done;
  logic          w_cpu_rst_nxt, w_done_nxt;
  logic          w_full, w_load_fire, w_last;

  assign w_full      = (r_len == 5'(DEPTH));
  assign load_ready  = (r_state == S_IDLE) && !w_full && !start && !clear_prog;
  assign w_load_fire = load_valid && load_ready;
  assign w_pc_inc    = r_pc + AW'(1);
  // Exit test against prog_len-1 so pc never has to reach DEPTH.
  assign w_last      = (5'(r_pc) == (r_len - 5'd1));

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_load_fire),
    .i_waddr (r_len[AW-1:0]),
    .i_wdata (load_instr),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are computed for the state being entered and registered with it,
  // so instr_out/cpu_rst line up with the state that owns them.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_rd_addr     = '0;
    w_instr_nxt   = NOP_INSTR;
    w_cpu_rst_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A clear in the same cycle wins: the program is being discarded.
        if (start && !clear_prog && (r_len != '0)) begin
          w_state_nxt   = S_CPURST;
          w_pc_nxt      = '0;
          w_cpu_rst_nxt = 1'b1;
        end
      end
      S_CPURST: begin
        w_state_nxt = S_RUN;
        w_pc_nxt    = '0;
        w_rd_addr   = '0;
        w_instr_nxt = w_rd_data;
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_pc_nxt    = w_pc_inc;
          w_rd_addr   = w_pc_inc;
          w_instr_nxt = w_rd_data;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_len     <= '0;
      r_instr   <= NOP_INSTR;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_cpu_rst <= w_cpu_rst_nxt;
      r_done    <= w_done_nxt;
      if (r_state == S_DRAIN) begin
        r_result <= cpu_out;
      end
      if ((r_state == S_IDLE) && clear_prog) begin
        r_len <= '0;
      end else if (w_load_fire) begin
        r_len <= r_len + 5'd1;
      end
    end
  end

  assign instr_out = r_instr;
  assign cpu_rst   = r_cpu_rst;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign prog_len  = r_len;

endmodule

// File: tb/tb_mccoy_sequencer.sv
module tb_mccoy_sequencer;

  localparam int          DEPTH = 16;
  localparam logic [5:0]  NOP   = 6'b100101;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [5:0] load_instr;
  logic       load_ready;
  logic       clear_prog;
  logic       start;
  logic [5:0] instr_out;
  logic       cpu_rst;
  logic [5:0] cpu_out;
  logic       busy;
  logic       done;
  logic [5:0] result;
  logic [4:0] prog_len;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int e0 = 0;

  logic [5:0] trace[$];
  logic [5:0] tr_prev[$];

  // Run-schedule model: m_d counts edges since start was accepted (-1 idle).
  int         m_len = 0;
  int         m_d = -1;
  int         m_n = 0;
  logic [5:0] m_res = '0;
  bit         m_rst = 1'b1;
  bit         mdl_valid = 1'b0;
  logic [5:0] m_prog [DEPTH];

  mccoy_sequencer #(
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_instr (load_instr),
    .load_ready (load_ready),
    .clear_prog (clear_prog),
    .start      (start),
    .instr_out  (instr_out),
    .cpu_rst    (cpu_rst),
    .cpu_out    (cpu_out),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .prog_len   (prog_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_len = 0;
      m_d   = -1;
      m_res = '0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (m_d >= 0) begin
        m_d++;
        if (m_d == m_n + 2) m_res = cpu_out;
        if (m_d == m_n + 3) m_d = -1;
      end else if (clear_prog) begin
        m_len = 0;
      end else if (start) begin
        if (m_len > 0) begin
          m_d = 0;
          m_n = m_len;
        end
      end else if (load_valid && m_len < DEPTH) begin
        m_prog[m_len] = load_instr;
        m_len++;
      end
    end
    mdl_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      logic [5:0] e_instr;
      e_instr = (m_d >= 1 && m_d <= m_n) ? m_prog[m_d-1] : NOP;
      chk("busy", busy, (m_d >= 0));
      chk("cpu_rst", cpu_rst, (m_rst || m_d == 0));
      chk("instr_out", instr_out, e_instr);
      chk("done", done, (m_d >= 0 && m_d == m_n + 2));
      chk("result", result, m_res);
      chk("prog_len", prog_len, m_len);
      chk("load_ready", load_ready,
          (m_d < 0 && m_len < DEPTH && !start && !clear_prog));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [5:0] w);
    load_valid = 1'b1;
    load_instr = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_run(input bit with_load, input bit mid_start, output int dcyc);
    trace.delete();
    dcyc  = -1;
    start = 1'b1;
    if (with_load) begin
      load_valid = 1'b1;
      load_instr = 6'h2a;
    end
    tick();
    e0 = cyc;
    start      = 1'b0;
    load_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mid_start) start = (i == 3);
      tick();
      trace.push_back(instr_out);
      if (done && dcyc < 0) dcyc = cyc - e0;
      if (!busy) break;
    end
    start = 1'b0;
  endtask

  function automatic logic [5:0] wfull(input int i);
    return 6'((i * 5 + 3) & 63);
  endfunction

  initial begin
    int dc;
    int diff;
    logic [5:0] res_prev;
    logic [5:0] p1 [6];
    p1 = '{6'b011000, 6'b010110, 6'b100000, 6'b011110, 6'b010000, 6'b010011};
    reset = 1'b1; load_valid = 1'b0; load_instr = '0;
    clear_prog = 1'b0; start = 1'b0; cpu_out = '0;
    tick(); tick();
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_instr", instr_out, NOP);
    chk("rst_len", prog_len, 5'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 6'd0);
    reset = 1'b0;
    tick();
    chk("rel_cpu_rst", cpu_rst, 1'b0);

    // start with empty program
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_busy", busy, 1'b0);
    chk("empty_cpu_rst", cpu_rst, 1'b0);
    tick(); tick();
    chk("empty_done", done, 1'b0);

    // six-word program
    for (int i = 0; i < 6; i++) load(p1[i]);
    chk("p1_len", prog_len, 5'd6);
    cpu_out = 6'd5;
    do_run(1'b0, 1'b0, dc);
    chk("p1_done_edge", dc, 8);
    chk("p1_result", result, 6'd5);
    chk("p1_tr0", trace[0], 6'b011000);
    chk("p1_tr5", trace[5], 6'b010011);
    chk("p1_tr6", trace[6], NOP);

    // append two words
    load(6'b010000); load(6'b011011);
    cpu_out = 6'b111110;
    do_run(1'b0, 1'b0, dc);
    chk("p2_done_edge", dc, 10);
    chk("p2_result", result, 6'b111110);
    chk("p2_tr7", trace[7], 6'b011011);
    tr_prev  = trace;
    res_prev = result;

    // replay with a start request while busy
    do_run(1'b0, 1'b1, dc);
    chk("rep_done_edge", dc, 10);
    diff = (trace.size() != tr_prev.size()) ? 1 : 0;
    if (diff == 0)
      foreach (trace[k]) if (trace[k] !== tr_prev[k]) diff++;
    chk("rep_trace_diff", diff, 0);
    chk("rep_result", result, res_prev);

    // start and load in the same cycle
    do_run(1'b1, 1'b0, dc);
    chk("sl_done_edge", dc, 10);
    chk("sl_len", prog_len, 5'd8);

    // fill to DEPTH, then one extra word
    clear_prog = 1'b1; tick(); clear_prog = 1'b0;
    chk("clr_len", prog_len, 5'd0);
    for (int i = 0; i < DEPTH; i++) load(wfull(i));
    load_valid = 1'b1; load_instr = 6'h3f;
    #1;
    chk("full_ready", load_ready, 1'b0);
    tick();
    load_valid = 1'b0;
    chk("full_len", prog_len, 5'd16);
    cpu_out = 6'd9;
    do_run(1'b0, 1'b0, dc);
    chk("full_done_edge", dc, 18);
    chk("full_tr0", trace[0], 6'd3);
    chk("full_tr15", trace[15], 6'd14);
    chk("full_result", result, 6'd9);

    // reset mid-run at word 3
    cpu_out = 6'd33;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_word3", instr_out, 6'd18);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_cpu_rst", cpu_rst, 1'b1);
    chk("mid_instr", instr_out, NOP);
    chk("mid_len", prog_len, 5'd0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_result", result, 6'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_done", done, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mccoy_sequencer.md
MCCOY_SEQUENCER -- requirements
Module: mccoy_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, sets program store entries (power of two, 2..16).
REQ-002 Parameter NOP_INSTR, default 6'b000000, is the instruction driven whenever no program word is issued.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 load_valid  in  1  with load_instr, request to append one program word.
REQ-006 load_instr  in  6  program word, same encoding as the McCoy instr field.
REQ-007 load_ready  out  1  combinational: state==IDLE and not full and not start and not clear_prog.
REQ-008 clear_prog  in  1  empties program store (length to 0); contents need not be erased.
REQ-009 start  in  1  request to replay the stored program into the core.
REQ-010 instr_out  out  6  registered instruction to core io_in[7:2].
REQ-011 cpu_rst  out  1  registered reset to core io_in[1].
REQ-012 cpu_out  in  6  core io_out[5:0].
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when result is valid.
REQ-015 result  out  6  cpu_out captured at end of run; held until next capture or reset.
REQ-016 prog_len  out  5  number of stored words, 0..DEPTH.

Function
REQ-017 Load: word written at index prog_len and prog_len increments on load_valid and load_ready.
REQ-018 Load when full, busy, or with start/clear_prog in same cycle: ignored, no state change.
REQ-019 clear_prog in IDLE sets prog_len to 0; clear_prog while busy is ignored.
REQ-020 FSM states IDLE, CPURST, RUN, DRAIN, DONE.
REQ-021 IDLE -> CPURST on start with prog_len>0; start with prog_len==0 ignored, start while busy ignored.
REQ-022 CPURST: one cycle, cpu_rst=1, instr_out=NOP_INSTR, pc cleared to 0.
REQ-023 RUN: each cycle instr_out=mem[pc], pc increments; exactly prog_len cycles, then DRAIN.
REQ-024 DRAIN: one cycle, instr_out=NOP_INSTR, cpu_rst=0.
REQ-025 DRAIN -> DONE: at that edge result <= cpu_out; DONE lasts one cycle with done=1, then IDLE.
REQ-026 Timing: start sampled at edge E0 gives cpu_rst high E0..E1, word k presented E(1+k)..E(2+k), done high E(N+2)..E(N+3), busy high E0..E(N+3).
REQ-027 Program store retained across runs; repeated start replays identical sequence.
REQ-028 pc never wraps: RUN exit compares pc against prog_len-1; prog_len==DEPTH supported.

Reset
REQ-029 On reset: state IDLE, prog_len 0, pc 0, instr_out NOP_INSTR, cpu_rst 1, done 0, result 0.
REQ-030 First cycle after reset released: cpu_rst 0.
REQ-031 Reset mid-run abandons run at next edge; no done pulse, result unchanged from reset value 0.

Structure
REQ-032 Package mccoy_seq_pkg holds state enum, DEPTH default, NOP_INSTR default, 6-bit instr type.
REQ-033 Program store is sub-module seq_prog_mem: DEPTH x 6 register array, one write port, one async read port, no reset on contents.

Verification
REQ-034 Load 011000,010110,100000,011110,010000,010011, start, McCoy instance attached -> prog_len 6, done at E8, result 5.
REQ-035 Append 010000,011011 to REQ-034 program, start -> done at E10, result 6'b111110 (-2 signed).
REQ-036 Load DEPTH words then one more -> load_ready 0 on extra word, prog_len stays DEPTH; run issues all DEPTH words in order.
REQ-037 start with prog_len 0 -> busy stays 0, cpu_rst stays 0, no done; start and load_valid same cycle -> load ignored, run length unchanged.
REQ-038 reset asserted during RUN at word 3 -> next cycle IDLE, instr_out NOP_INSTR, cpu_rst 1, prog_len 0, no done.
REQ-039 Two back-to-back starts after one load -> identical instr_out traces and identical result; start during busy ignored.
